// File: rtl/fragment_depth_writer_if.sv
// Fragment writer bus: FIFO drain side, depth buffer port, colour buffer port and control.
// The master side drives configuration and memory/FIFO responses; the writer sits on the slave side.
interface fragment_depth_writer_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int FB_ADDR_WIDTH = 20
);
   logic                     en;
   logic                     start;
   logic                     upstream_done;
   logic                     ready;
   logic                     done;
   logic [DATA_WIDTH-1:0]    frag_fifo_rd_data;
   logic                     frag_fifo_rd_en;
   logic                     frag_fifo_empty;
   logic [31:0]              resx;
   logic [31:0]              resy;
   logic                     depth_test_en;
   logic [1:0]               depth_func;
   logic                     depth_write_en;
   logic [FB_ADDR_WIDTH-1:0] depth_rd_addr;
   logic                     depth_rd_en;
   logic [DATA_WIDTH-1:0]    depth_rd_data;
   logic [FB_ADDR_WIDTH-1:0] depth_wr_addr;
   logic [DATA_WIDTH-1:0]    depth_wr_data;
   logic                     depth_wr_en;
   logic [FB_ADDR_WIDTH-1:0] fb_wr_addr;
   logic [DATA_WIDTH-1:0]    fb_wr_data;
   logic                     fb_wr_en;
   logic [31:0]              frags_written;
   logic [31:0]              frags_discarded;

   modport master (
      output en, start, upstream_done, frag_fifo_rd_data, frag_fifo_empty,
             resx, resy, depth_test_en, depth_func, depth_write_en, depth_rd_data,
      input  ready, done, frag_fifo_rd_en, depth_rd_addr, depth_rd_en,
             depth_wr_addr, depth_wr_data, depth_wr_en, fb_wr_addr, fb_wr_data, fb_wr_en,
             frags_written, frags_discarded
   );

   modport slave (
      input  en, start, upstream_done, frag_fifo_rd_data, frag_fifo_empty,
             resx, resy, depth_test_en, depth_func, depth_write_en, depth_rd_data,
      output ready, done, frag_fifo_rd_en, depth_rd_addr, depth_rd_en,
             depth_wr_addr, depth_wr_data, depth_wr_en, fb_wr_addr, fb_wr_data, fb_wr_en,
             frags_written, frags_discarded
   );
endinterface

// File: rtl/fragment_depth_writer.sv
// Final raster stage: drains 3-word fragment records, depth-tests them and writes
// passing fragments to the colour framebuffer, one triangle per start/done transaction.
module fragment_depth_writer #(
   parameter int DATA_WIDTH    = 32,
   parameter int FB_ADDR_WIDTH = 20,
   parameter int MEM_LATENCY   = 1
) (
   input logic                  clk,
   input logic                  reset,
   fragment_depth_writer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, READ, CHECK, DEPTH_WAIT, WRITE, DONE} state_t;

   localparam int CNT_W = $clog2(MEM_LATENCY + 1) + 1;

   state_t                   state;
   logic [1:0]               issued;
   logic [1:0]               captured;
   logic                     pop_pending;
   logic [CNT_W-1:0]         wait_cnt;
   logic [FB_ADDR_WIDTH-1:0] addr_reg;
   logic                     ready_reg;
   logic                     done_reg;
   logic                     depth_rd_en_reg;
   logic [FB_ADDR_WIDTH-1:0] depth_rd_addr_reg;
   logic                     depth_wr_en_reg;
   logic                     fb_wr_en_reg;
   logic [FB_ADDR_WIDTH-1:0] wr_addr_reg;
   logic [DATA_WIDTH-1:0]    depth_wr_data_reg;
   logic [DATA_WIDTH-1:0]    fb_wr_data_reg;
   logic [31:0]              written_reg;
   logic [31:0]              discarded_reg;

   logic [DATA_WIDTH-1:0]    word [3];
   logic                     rd_en;
   logic [15:0]              frag_x;
   logic [15:0]              frag_y;
   logic [DATA_WIDTH-1:0]    frag_z;
   logic [FB_ADDR_WIDTH-1:0] pix_addr;
   logic                     discard;
   logic                     bypass;
   logic                     depth_pass;

   // Record word registers; a pop issued last cycle lands in the next free slot even with en low.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_word
         logic [DATA_WIDTH-1:0] word_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               word_reg <= '0;
            else if (pop_pending && captured == 2'(gi))
               word_reg <= bus.frag_fifo_rd_data;
         end
         assign word[gi] = word_reg;
      end
   endgenerate

   assign rd_en    = (state == READ) && bus.en && !bus.frag_fifo_empty && (issued < 2'd3);
   assign frag_x   = word[0][31:16];
   assign frag_y   = word[0][15:0];
   assign frag_z   = word[1];
   assign pix_addr = FB_ADDR_WIDTH'(({16'd0, bus.resx} * {32'd0, frag_y}) + {32'd0, frag_x});

   assign discard = ({16'd0, frag_x} >= bus.resx) || ({16'd0, frag_y} >= bus.resy) ||
                    frag_z[DATA_WIDTH-1] || (bus.depth_test_en && bus.depth_func == 2'b11);
   assign bypass  = !bus.depth_test_en || bus.depth_func == 2'b10;

   // Non-negative IEEE floats order the same as their unsigned bit patterns.
   always_comb begin
      depth_pass = 1'b0;
      case (bus.depth_func)
         2'b00:   depth_pass = frag_z <  bus.depth_rd_data;
         2'b01:   depth_pass = frag_z <= bus.depth_rd_data;
         2'b10:   depth_pass = 1'b1;
         default: depth_pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         issued            <= '0;
         captured          <= '0;
         pop_pending       <= 1'b0;
         wait_cnt          <= '0;
         addr_reg          <= '0;
         ready_reg         <= 1'b1;
         done_reg          <= 1'b0;
         depth_rd_en_reg   <= 1'b0;
         depth_rd_addr_reg <= '0;
         depth_wr_en_reg   <= 1'b0;
         fb_wr_en_reg      <= 1'b0;
         wr_addr_reg       <= '0;
         depth_wr_data_reg <= '0;
         fb_wr_data_reg    <= '0;
         written_reg       <= '0;
         discarded_reg     <= '0;
      end else begin
         pop_pending <= rd_en;
         if (pop_pending)
            captured <= captured + 2'd1;
         done_reg        <= 1'b0;
         depth_rd_en_reg <= 1'b0;
         depth_wr_en_reg <= 1'b0;
         fb_wr_en_reg    <= 1'b0;
         if (bus.en) begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     state     <= READ;
                     ready_reg <= 1'b0;
                     issued    <= '0;
                  end
               end
               READ: begin
                  if (rd_en)
                     issued <= issued + 2'd1;
                  if (captured == 2'd3) begin
                     state    <= CHECK;
                     issued   <= '0;
                     captured <= '0;
                  end else if (issued == 2'd0 && bus.frag_fifo_empty && bus.upstream_done) begin
                     state    <= DONE;
                     done_reg <= 1'b1;
                  end
               end
               CHECK: begin
                  addr_reg <= pix_addr;
                  if (discard) begin
                     discarded_reg <= discarded_reg + 32'd1;
                     state         <= READ;
                  end else if (bypass) begin
                     fb_wr_en_reg      <= 1'b1;
                     fb_wr_data_reg    <= word[2];
                     depth_wr_en_reg   <= bus.depth_write_en;
                     depth_wr_data_reg <= frag_z;
                     wr_addr_reg       <= pix_addr;
                     written_reg       <= written_reg + 32'd1;
                     state             <= WRITE;
                  end else begin
                     depth_rd_en_reg   <= 1'b1;
                     depth_rd_addr_reg <= pix_addr;
                     wait_cnt          <= '0;
                     state             <= DEPTH_WAIT;
                  end
               end
               DEPTH_WAIT: begin
                  if (wait_cnt == CNT_W'(MEM_LATENCY)) begin
                     if (depth_pass) begin
                        fb_wr_en_reg      <= 1'b1;
                        fb_wr_data_reg    <= word[2];
                        depth_wr_en_reg   <= bus.depth_write_en;
                        depth_wr_data_reg <= frag_z;
                        wr_addr_reg       <= addr_reg;
                        written_reg       <= written_reg + 32'd1;
                        state             <= WRITE;
                     end else begin
                        discarded_reg <= discarded_reg + 32'd1;
                        state         <= READ;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + CNT_W'(1);
                  end
               end
               WRITE: state <= READ;
               DONE: begin
                  ready_reg <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.ready           = ready_reg;
   assign bus.done            = done_reg;
   assign bus.frag_fifo_rd_en = rd_en;
   assign bus.depth_rd_en     = depth_rd_en_reg;
   assign bus.depth_rd_addr   = depth_rd_addr_reg;
   assign bus.depth_wr_en     = depth_wr_en_reg;
   assign bus.depth_wr_addr   = wr_addr_reg;
   assign bus.depth_wr_data   = depth_wr_data_reg;
   assign bus.fb_wr_en        = fb_wr_en_reg;
   assign bus.fb_wr_addr      = wr_addr_reg;
   assign bus.fb_wr_data      = fb_wr_data_reg;
   assign bus.frags_written   = written_reg;
   assign bus.frags_discarded = discarded_reg;
endmodule

// File: tb/tb_fragment_depth_writer.sv
// Scoreboard bench for fragment_depth_writer: FIFO and depth memory models, write/read monitors,
// and per-scenario tasks that compare observed traffic and counters against a reference model.
module tb_fragment_depth_writer;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fragment_depth_writer_if #(.DATA_WIDTH(32), .FB_ADDR_WIDTH(20)) bus ();

   fragment_depth_writer #(.DATA_WIDTH(32), .FB_ADDR_WIDTH(20), .MEM_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // FIFO model
   logic [31:0] fifo_mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign bus.frag_fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (bus.frag_fifo_rd_en) begin
         bus.frag_fifo_rd_data <= fifo_mem[rd_ptr % 256];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Depth memory with LAT-cycle read latency; data outside the valid slot reads as 0
   logic [31:0] dmem [4096];
   logic [31:0] rd_pipe [LAT];
   logic        rd_vld [LAT];
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = '0;
   logic [31:0] poke_data = '0;
   always @(posedge clk) begin
      if (poke_en) dmem[poke_addr] <= poke_data;
      if (bus.depth_wr_en) dmem[bus.depth_wr_addr[11:0]] <= bus.depth_wr_data;
      rd_vld[0]  <= bus.depth_rd_en;
      rd_pipe[0] <= dmem[bus.depth_rd_addr[11:0]];
      for (int i = 1; i < LAT; i++) begin
         rd_vld[i]  <= rd_vld[i-1];
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign bus.depth_rd_data = (rd_vld[LAT-1] === 1'b1) ? rd_pipe[LAT-1] : 32'h0;

   // Output monitor
   logic [19:0] obs_fb_addr [256];
   logic [31:0] obs_fb_data [256];
   logic        obs_dw_en   [256];
   logic [19:0] obs_dw_addr [256];
   logic [31:0] obs_dw_data [256];
   logic [19:0] obs_rd_addr [256];
   int obs_wr_n = 0;
   int obs_rd_n = 0;
   int obs_stray_n = 0;
   always @(negedge clk) begin
      if (bus.fb_wr_en === 1'b1) begin
         obs_fb_addr[obs_wr_n % 256] <= bus.fb_wr_addr;
         obs_fb_data[obs_wr_n % 256] <= bus.fb_wr_data;
         obs_dw_en[obs_wr_n % 256]   <= bus.depth_wr_en;
         obs_dw_addr[obs_wr_n % 256] <= bus.depth_wr_addr;
         obs_dw_data[obs_wr_n % 256] <= bus.depth_wr_data;
         obs_wr_n <= obs_wr_n + 1;
      end else if (bus.depth_wr_en === 1'b1) begin
         obs_stray_n <= obs_stray_n + 1;
      end
      if (bus.depth_rd_en === 1'b1) begin
         obs_rd_addr[obs_rd_n % 256] <= bus.depth_rd_addr;
         obs_rd_n <= obs_rd_n + 1;
      end
   end

   // Reference model state
   typedef struct packed {
      logic [19:0] addr;
      logic [31:0] col;
      logic        dw;
      logic [31:0] z;
   } exp_t;
   exp_t        exp_wr_q [$];
   logic [19:0] exp_rd_q [$];
   logic [31:0] model_depth [4096];
   int exp_written = 0;
   int exp_discarded = 0;
   int wr_seen = 0;
   int rd_seen = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [19:0] a, input logic [31:0] d);
      poke_addr = a[11:0];
      poke_data = d;
      poke_en = 1'b1;
      model_depth[a[11:0]] = d;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      fifo_mem[wr_ptr % 256] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic model_frag(input logic [15:0] x, input logic [15:0] y,
                             input logic [31:0] z, input logic [31:0] col);
      logic [63:0] full;
      logic [19:0] a;
      logic        pass;
      logic [31:0] d;
      exp_t        e;
      full = {32'd0, bus.resx} * {48'd0, y} + {48'd0, x};
      a = full[19:0];
      if ({16'd0, x} >= bus.resx || {16'd0, y} >= bus.resy || z[31] ||
          (bus.depth_test_en && bus.depth_func == 2'b11))
         pass = 1'b0;
      else if (!bus.depth_test_en || bus.depth_func == 2'b10)
         pass = 1'b1;
      else begin
         exp_rd_q.push_back(a);
         d = model_depth[a[11:0]];
         pass = (bus.depth_func == 2'b00) ? (z < d) : (z <= d);
      end
      if (pass) begin
         e.addr = a; e.col = col; e.dw = bus.depth_write_en; e.z = z;
         exp_wr_q.push_back(e);
         if (bus.depth_write_en) model_depth[a[11:0]] = z;
         exp_written++;
      end else begin
         exp_discarded++;
      end
   endtask

   task automatic push_frag(input logic [15:0] x, input logic [15:0] y,
                            input logic [31:0] z, input logic [31:0] col);
      model_frag(x, y, z, col);
      push_word({x, y});
      push_word(z);
      push_word(col);
   endtask

   task automatic wait_done_and_drain(input string name);
      int   n;
      exp_t e;
      logic [19:0] ra;
      bus.upstream_done = 1'b1;
      n = 0;
      while (bus.done !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_timeout got done=%b after %0d cycles, need 1", name, bus.done, n);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL %s done_pulse got done=%b ready=%b, need done=0 ready=1", name, bus.done, bus.ready);
      end
      bus.upstream_done = 1'b0;
      while (exp_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         checks++;
         if (wr_seen >= obs_wr_n) begin
            errors++;
            $display("FAIL %s missing_write got none, need addr=%0d col=%h", name, e.addr, e.col);
         end else begin
            if (obs_fb_addr[wr_seen % 256] !== e.addr || obs_fb_data[wr_seen % 256] !== e.col ||
                obs_dw_en[wr_seen % 256] !== e.dw ||
                (e.dw && (obs_dw_addr[wr_seen % 256] !== e.addr || obs_dw_data[wr_seen % 256] !== e.z))) begin
               errors++;
               $display("FAIL %s write got addr=%0d col=%h dw=%b daddr=%0d z=%h, need addr=%0d col=%h dw=%b z=%h",
                        name, obs_fb_addr[wr_seen % 256], obs_fb_data[wr_seen % 256], obs_dw_en[wr_seen % 256],
                        obs_dw_addr[wr_seen % 256], obs_dw_data[wr_seen % 256], e.addr, e.col, e.dw, e.z);
            end
            wr_seen++;
         end
      end
      while (exp_rd_q.size() > 0) begin
         ra = exp_rd_q.pop_front();
         checks++;
         if (rd_seen >= obs_rd_n) begin
            errors++;
            $display("FAIL %s missing_depth_read got none, need addr=%0d", name, ra);
         end else begin
            if (obs_rd_addr[rd_seen % 256] !== ra) begin
               errors++;
               $display("FAIL %s depth_rd_addr got %0d, need %0d", name, obs_rd_addr[rd_seen % 256], ra);
            end
            rd_seen++;
         end
      end
      checks++;
      if (obs_wr_n != wr_seen || obs_rd_n != rd_seen || obs_stray_n != 0) begin
         errors++;
         $display("FAIL %s extra_traffic got writes=%0d reads=%0d stray=%0d, need writes=%0d reads=%0d stray=0",
                  name, obs_wr_n, obs_rd_n, obs_stray_n, wr_seen, rd_seen);
         wr_seen = obs_wr_n;
         rd_seen = obs_rd_n;
      end
      checks++;
      if (bus.frags_written !== 32'(exp_written) || bus.frags_discarded !== 32'(exp_discarded)) begin
         errors++;
         $display("FAIL %s counters got written=%0d discarded=%0d, need written=%0d discarded=%0d",
                  name, bus.frags_written, bus.frags_discarded, exp_written, exp_discarded);
      end
      $display("triangle %s: written=%0d discarded=%0d", name, bus.frags_written, bus.frags_discarded);
   endtask

   task automatic start_triangle();
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_triangle(input string name);
      start_triangle();
      wait_done_and_drain(name);
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({bus.ready, bus.done, bus.frag_fifo_rd_en, bus.depth_rd_en, bus.depth_wr_en, bus.fb_wr_en} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_strobes got rdy/done/pop/drd/dwr/fbwr=%b, need 100000",
                  {bus.ready, bus.done, bus.frag_fifo_rd_en, bus.depth_rd_en, bus.depth_wr_en, bus.fb_wr_en});
      end
      checks++;
      if (bus.frags_written !== 32'd0 || bus.frags_discarded !== 32'd0 || bus.fb_wr_addr !== 20'd0 ||
          bus.depth_rd_addr !== 20'd0 || bus.fb_wr_data !== 32'd0 || bus.depth_wr_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_values got wr=%0d disc=%0d fbaddr=%0d rdaddr=%0d, need all 0",
                  bus.frags_written, bus.frags_discarded, bus.fb_wr_addr, bus.depth_rd_addr);
      end
      rst = 1'b0;
      tick();
      run_triangle("empty");
   endtask

   task automatic test_basic();
      bus.depth_test_en = 1'b1; bus.depth_func = 2'b00; bus.depth_write_en = 1'b1;
      poke(20'd1283, 32'h3F800000);
      push_frag(16'd3, 16'd2, 32'h3F000000, 32'hFF0000FF);
      run_triangle("basic");
   endtask

   task automatic test_same_pixel();
      push_frag(16'd3, 16'd2, 32'h3F000000, 32'h00FF00FF);
      run_triangle("same_less");
      bus.depth_func = 2'b01;
      push_frag(16'd3, 16'd2, 32'h3F000000, 32'h0000FFFF);
      run_triangle("same_lequal");
   endtask

   task automatic test_bounds();
      bus.depth_func = 2'b00;
      push_frag(16'd640, 16'd2, 32'h3E000000, 32'h11111111);
      push_frag(16'd3, 16'd480, 32'h3E000000, 32'h22222222);
      push_frag(16'd3, 16'd2, 32'hBF800000, 32'h33333333);
      run_triangle("bounds");
      bus.depth_func = 2'b11;
      push_frag(16'd1, 16'd1, 32'h3E000000, 32'h44444444);
      run_triangle("never");
   endtask

   task automatic test_gaps();
      bus.depth_func = 2'b00;
      poke(20'd1927, 32'h40000000);
      start_triangle();
      model_frag(16'd7, 16'd3, 32'h3F400000, 32'hABCDEF01);
      push_word({16'd7, 16'd3});
      repeat (4) tick();
      push_word(32'h3F400000);
      tick();
      bus.en = 1'b0;
      push_word(32'hABCDEF01);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.frag_fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL gaps pop_while_disabled got %b, need 0 (cycle %0d)", bus.frag_fifo_rd_en, i);
         end
         tick();
      end
      bus.en = 1'b1;
      push_frag(16'd7, 16'd3, 32'h3F400000, 32'h12345678);
      wait_done_and_drain("gaps");
   endtask

   task automatic test_back_to_back();
      logic [15:0] px [4];
      logic [15:0] py [4];
      int sel;
      logic [31:0] z;
      px[0] = 16'd10; py[0] = 16'd10;
      px[1] = 16'd11; py[1] = 16'd10;
      px[2] = 16'd10; py[2] = 16'd11;
      px[3] = 16'd0;  py[3] = 16'd0;
      for (int p = 0; p < 4; p++)
         poke(20'(px[p] + 640 * py[p]), 32'h3F000000 + 32'($urandom_range(0, 3)) * 32'h00100000);
      for (int t = 0; t < 4; t++) begin
         bus.depth_func = 2'($urandom_range(0, 3));
         bus.depth_test_en = (t != 2);
         bus.depth_write_en = 1'($urandom_range(0, 1));
         for (int f = 0; f < 6; f++) begin
            sel = $urandom_range(0, 3);
            z = 32'h3F000000 + 32'($urandom_range(0, 3)) * 32'h00100000;
            if (f == 5) z[31] = 1'b1;
            push_frag(px[sel], py[sel], z, $urandom);
         end
         run_triangle($sformatf("b2b_%0d", t));
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] saved;
      int n;
      bus.depth_test_en = 1'b1; bus.depth_func = 2'b00; bus.depth_write_en = 1'b1;
      poke(20'd3205, 32'h3F800000);
      saved = model_depth[12'(3205)];
      push_frag(16'd5, 16'd5, 32'h3F000000, 32'hCAFEF00D);
      start_triangle();
      n = 0;
      while (bus.depth_rd_en !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (bus.depth_rd_en !== 1'b1 || bus.depth_rd_addr !== exp_rd_q[0]) begin
         errors++;
         $display("FAIL reset_mid depth_read got en=%b addr=%0d, need en=1 addr=%0d", bus.depth_rd_en, bus.depth_rd_addr, exp_rd_q[0]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.ready, bus.done, bus.depth_rd_en, bus.fb_wr_en} !== 4'b1000 || bus.depth_rd_addr !== 20'd0 ||
          bus.frags_written !== 32'd0 || bus.frags_discarded !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid async_reset got rdy/done/drd/fbwr=%b rdaddr=%0d wr=%0d disc=%0d, need 1000 0 0 0",
                  {bus.ready, bus.done, bus.depth_rd_en, bus.fb_wr_en}, bus.depth_rd_addr, bus.frags_written, bus.frags_discarded);
      end
      void'(exp_rd_q.pop_front());
      exp_wr_q.delete();
      model_depth[12'(3205)] = saved;
      exp_written = 0;
      exp_discarded = 0;
      tick();
      tick();
      rst = 1'b0;
      wr_seen = obs_wr_n;
      rd_seen = obs_rd_n;
      tick();
      push_frag(16'd5, 16'd5, 32'h3F200000, 32'h0BADBEEF);
      run_triangle("after_reset");
   endtask

   initial begin
      bus.en = 1'b1;
      bus.start = 1'b0;
      bus.upstream_done = 1'b0;
      bus.resx = 32'd640;
      bus.resy = 32'd480;
      bus.depth_test_en = 1'b1;
      bus.depth_func = 2'b00;
      bus.depth_write_en = 1'b1;
      for (int i = 0; i < 4096; i++) model_depth[i] = 32'h0;
      test_reset();
      test_basic();
      test_same_pixel();
      test_bounds();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
